// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined ALU and anything that decodes its ops.
package alu_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [3:0] {
        OP_ADC  = 4'd0,
        OP_SBC  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORA  = 4'd3,
        OP_EOR  = 4'd4,
        OP_ASL  = 4'd5,
        OP_LSR  = 4'd6,
        OP_ROL  = 4'd7,
        OP_ROR  = 4'd8,
        OP_INC  = 4'd9,
        OP_DEC  = 4'd10,
        OP_CMP  = 4'd11,
        OP_PASS = 4'd12
    } alu_op_t;

endpackage

// File: rtl/bcd_adjust.sv
// One-nibble decimal correction: +6 after a decimal carry on add, -6 after a borrow on subtract.
module bcd_adjust (
    input  logic [3:0] nib_in,
    input  logic       adjust,
    input  logic       sub,
    output logic [3:0] nib_out
);

    always_comb begin
        nib_out = nib_in;
        if (adjust) begin
            nib_out = sub ? (nib_in - 4'd6) : (nib_in + 4'd6);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU: S1 computes the raw result and per-nibble carries, S2 applies
// BCD correction and registers result/flags. Valid/ready handshake on both sides.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          DECIMAL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned NIBS = WIDTH / NIBBLE_W;

    alu_op_t          op_e;
    logic             is_sub;
    logic             dec_mode;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] bin_sum;
    logic             bin_c;
    logic             bin_v;
    logic [WIDTH-1:0] cmp_diff;
    logic             cmp_c;
    logic [WIDTH-1:0] dec_sum;
    logic [NIBS-1:0]  dec_adj;
    logic             dec_c;
    logic [4:0]       nsum;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [NIBS-1:0]  alu_adj;

    logic             s1_valid_d, s1_valid_q;
    logic [WIDTH-1:0] s1_res_d,   s1_res_q;
    logic             s1_c_d,     s1_c_q;
    logic             s1_v_d,     s1_v_q;
    logic             s1_sub_d,   s1_sub_q;
    logic [NIBS-1:0]  s1_adj_d,   s1_adj_q;

    logic             s2_valid_d, s2_valid_q;
    logic [WIDTH-1:0] res_d,      res_q;
    logic             c_d,        c_q;
    logic             v_d,        v_q;
    logic             z_d,        z_q;
    logic             n_d,        n_q;

    logic             s2_adv;
    logic [WIDTH-1:0] adj_res;

    assign op_e     = alu_op_t'(op);
    assign is_sub   = (op_e == OP_SBC);
    assign dec_mode = DECIMAL_EN && decimal && ((op_e == OP_ADC) || (op_e == OP_SBC));
    assign add_b    = is_sub ? ~b : b;

    assign {bin_c, bin_sum}  = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, carry_in};
    assign bin_v             = (a[WIDTH-1] ^ bin_sum[WIDTH-1]) & (add_b[WIDTH-1] ^ bin_sum[WIDTH-1]);
    assign {cmp_c, cmp_diff} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Decimal chain: the carry into each nibble is the decimal carry (sum > 9) on
    // add or the raw nibble carry on subtract; S2 only has to apply the +/-6.
    always_comb begin
        dec_sum = '0;
        dec_adj = '0;
        dec_c   = carry_in;
        nsum    = '0;
        for (int unsigned k = 0; k < NIBS; k++) begin
            nsum = {1'b0, a[NIBBLE_W*k +: NIBBLE_W]} + {1'b0, add_b[NIBBLE_W*k +: NIBBLE_W]} + {4'b0, dec_c};
            dec_sum[NIBBLE_W*k +: NIBBLE_W] = nsum[3:0];
            if (is_sub) begin
                dec_adj[k] = ~nsum[4];
                dec_c      = nsum[4];
            end else begin
                dec_adj[k] = (nsum > 5'd9);
                dec_c      = dec_adj[k];
            end
        end
    end

    always_comb begin
        alu_res = a;
        alu_c   = carry_in;
        alu_v   = 1'b0;
        alu_adj = '0;
        case (op_e)
            OP_ADC, OP_SBC: begin
                alu_v = bin_v;
                if (dec_mode) begin
                    alu_res = dec_sum;
                    alu_c   = dec_c;
                    alu_adj = dec_adj;
                end else begin
                    alu_res = bin_sum;
                    alu_c   = bin_c;
                end
            end
            OP_AND: alu_res = a & b;
            OP_ORA: alu_res = a | b;
            OP_EOR: alu_res = a ^ b;
            OP_ASL: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_c   = a[WIDTH-1];
            end
            OP_LSR: begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            OP_ROL: begin
                alu_res = {a[WIDTH-2:0], carry_in};
                alu_c   = a[WIDTH-1];
            end
            OP_ROR: begin
                alu_res = {carry_in, a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            OP_INC: alu_res = a + WIDTH'(1);
            OP_DEC: alu_res = a - WIDTH'(1);
            OP_CMP: begin
                alu_res = cmp_diff;
                alu_c   = cmp_c;
            end
            default: alu_res = a;
        endcase
    end

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_res_d   = s1_res_q;
        s1_c_d     = s1_c_q;
        s1_v_d     = s1_v_q;
        s1_sub_d   = s1_sub_q;
        s1_adj_d   = s1_adj_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_ready && in_valid) begin
            s1_res_d = alu_res;
            s1_c_d   = alu_c;
            s1_v_d   = alu_v;
            s1_sub_d = is_sub;
            s1_adj_d = alu_adj;
        end
    end

    for (genvar g = 0; g < NIBS; g++) begin : g_adj
        bcd_adjust u_bcd_adjust (
            .nib_in  (s1_res_q[NIBBLE_W*g +: NIBBLE_W]),
            .adjust  (s1_adj_q[g]),
            .sub     (s1_sub_q),
            .nib_out (adj_res[NIBBLE_W*g +: NIBBLE_W])
        );
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        c_d        = c_q;
        v_d        = v_q;
        z_d        = z_q;
        n_d        = n_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            res_d = adj_res;
            c_d   = s1_c_q;
            v_d   = s1_v_q;
            z_d   = (adj_res == '0);
            n_d   = adj_res[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_c_q     <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_adj_q   <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            c_q        <= 1'b0;
            v_q        <= 1'b0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s1_c_q     <= s1_c_d;
            s1_v_q     <= s1_v_d;
            s1_sub_q   <= s1_sub_d;
            s1_adj_q   <= s1_adj_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            c_q        <= c_d;
            v_q        <= v_d;
            z_q        <= z_d;
            n_q        <= n_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = res_q;
    assign carry_out = c_q;
    assign overflow  = v_q;
    assign zero      = z_q;
    assign negative  = n_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomised checks of alu_pipe against a behavioural model via a result scoreboard.
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        carry_in = 1'b0;
    logic        decimal = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  result;
    logic        carry_out, overflow, zero, negative;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [3:0]  op16 = 4'd0;
    logic [15:0] a16 = 16'd0;
    logic [15:0] b16 = 16'd0;
    logic        carry_in16 = 1'b0;
    logic        decimal16 = 1'b0;
    logic        out_valid16;
    logic [15:0] result16;
    logic        carry_out16, overflow16, zero16, negative16;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .carry_in(carry_in), .decimal(decimal),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero), .negative(negative)
    );

    alu_pipe #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .a(a16), .b(b16), .carry_in(carry_in16), .decimal(decimal16),
        .out_valid(out_valid16), .out_ready(1'b1), .result(result16),
        .carry_out(carry_out16), .overflow(overflow16), .zero(zero16), .negative(negative16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int bcd2int(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                   input logic c, input logic d);
        exp_t       e;
        logic [7:0] yy;
        logic [8:0] t;
        int         s;
        e.r = x;
        e.c = c;
        e.v = 1'b0;
        case (o)
            OP_ADC, OP_SBC: begin
                yy  = (o == OP_SBC) ? ~y : y;
                t   = {1'b0, x} + {1'b0, yy} + {8'd0, c};
                e.r = t[7:0];
                e.c = t[8];
                e.v = (x[7] == yy[7]) && (t[7] != x[7]);
                if (d) begin
                    if (o == OP_ADC) begin
                        s   = bcd2int(x) + bcd2int(y) + int'(c);
                        e.c = (s >= 100);
                        e.r = int2bcd(s % 100);
                    end else begin
                        s   = bcd2int(x) - bcd2int(y) - (c ? 0 : 1);
                        e.c = (s >= 0);
                        e.r = int2bcd((s < 0) ? s + 100 : s);
                    end
                end
            end
            OP_AND: e.r = x & y;
            OP_ORA: e.r = x | y;
            OP_EOR: e.r = x ^ y;
            OP_ASL: begin e.r = x << 1;      e.c = x[7]; end
            OP_LSR: begin e.r = x >> 1;      e.c = x[0]; end
            OP_ROL: begin e.r = {x[6:0], c}; e.c = x[7]; end
            OP_ROR: begin e.r = {c, x[7:1]}; e.c = x[0]; end
            OP_INC: e.r = x + 8'd1;
            OP_DEC: e.r = x - 8'd1;
            OP_CMP: begin e.r = x - y; e.c = (x >= y); end
            default: e.r = x;
        endcase
        e.z = (e.r == 8'd0);
        e.n = e.r[7];
        return e;
    endfunction

    function automatic logic [7:0] rand_bcd();
        logic [3:0] hi, lo;
        hi = 4'($urandom_range(0, 9));
        lo = 4'($urandom_range(0, 9));
        return {hi, lo};
    endfunction

    task automatic present(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                           input logic c, input logic d);
        op = o; a = x; b = y; carry_in = c; decimal = d; in_valid = 1'b1;
    endtask

    // Holds the request until accepted, pushes its expectation, returns just after the accepting edge.
    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic d);
        bit accepted;
        accepted = 1'b0;
        present(o, x, y, c, d);
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(o, x, y, c, d));
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) chk("send_timeout", 32'(accepted), 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("flags_cvzn", {28'd0, carry_out, overflow, zero, negative}, {28'd0, e.c, e.v, e.z, e.n});
            end
        end
    end

    initial begin
        bit          seen;
        logic [3:0]  rop;
        logic        rdec;
        logic [7:0]  ra, rb;

        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", {28'd0, carry_out, overflow, zero, negative}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Two-cycle latency on the first op
        send(OP_ADC, 8'h50, 8'h50, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("lat_cycle1_invalid", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(out_valid), 1);
        @(posedge clk); #1;

        // Directed vectors streamed back to back
        send(OP_ADC, 8'h58, 8'h46, 1'b1, 1'b1);
        send(OP_SBC, 8'h46, 8'h12, 1'b1, 1'b1);
        send(OP_SBC, 8'h12, 8'h46, 1'b1, 1'b1);
        send(OP_ADC, 8'h99, 8'h99, 1'b1, 1'b1);
        send(OP_SBC, 8'h00, 8'h01, 1'b1, 1'b0);
        send(OP_CMP, 8'h10, 8'h10, 1'b0, 1'b0);
        send(OP_CMP, 8'h0F, 8'h10, 1'b1, 1'b0);
        send(OP_ROR, 8'h01, 8'h00, 1'b1, 1'b0);
        send(OP_ASL, 8'h80, 8'h00, 1'b0, 1'b0);
        send(OP_LSR, 8'h81, 8'h00, 1'b0, 1'b0);
        send(OP_ROL, 8'h80, 8'h00, 1'b1, 1'b0);
        send(OP_AND, 8'hF0, 8'h3C, 1'b1, 1'b1);
        send(OP_ORA, 8'h0F, 8'h30, 1'b0, 1'b0);
        send(OP_EOR, 8'hFF, 8'hFF, 1'b1, 1'b0);
        send(OP_INC, 8'hFF, 8'h00, 1'b0, 1'b0);
        send(OP_DEC, 8'h00, 8'h00, 1'b1, 1'b0);
        send(OP_PASS, 8'hA5, 8'h00, 1'b0, 1'b0);
        send(4'hF, 8'h3C, 8'hFF, 1'b1, 1'b0);
        send(OP_ADC, 8'h7F, 8'h01, 1'b0, 1'b0);
        idle();

        // Randomised stream, BCD operands when decimal is set
        for (int i = 0; i < 24; i++) begin
            rop  = 4'($urandom_range(0, 15));
            rdec = 1'($urandom_range(0, 1));
            if (rdec && (rop == OP_ADC || rop == OP_SBC)) begin
                ra = rand_bcd();
                rb = rand_bcd();
            end else begin
                ra = 8'($urandom);
                rb = 8'($urandom);
            end
            send(rop, ra, rb, 1'($urandom_range(0, 1)), rdec);
        end
        idle();
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
        chk("drain_stream", 32'(sb.size()), 0);
        @(posedge clk); #1;

        // Backpressure: fill both stages, hold, then release
        out_ready = 1'b0;
        present(OP_EOR, 8'h5A, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_ir_empty", 32'(in_ready), 1);
        sb.push_back(model(OP_EOR, 8'h5A, 8'hFF, 1'b0, 1'b0));
        @(posedge clk); #1;
        present(OP_INC, 8'h41, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("stall_ir_one", 32'(in_ready), 1);
        sb.push_back(model(OP_INC, 8'h41, 8'h00, 1'b1, 1'b0));
        @(posedge clk); #1;
        present(OP_ADC, 8'h19, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ir_full", 32'(in_ready), 0);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_hold_result", 32'(result), 32'(sb[0].r));
            chk("stall_hold_flags", {28'd0, carry_out, overflow, zero, negative},
                {28'd0, sb[0].c, sb[0].v, sb[0].z, sb[0].n});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(OP_ADC, 8'h19, 8'h01, 1'b0, 1'b1);
        idle();
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
        chk("drain_stall", 32'(sb.size()), 0);
        @(posedge clk); #1;

        // Reset with two ops in flight
        out_ready = 1'b0;
        send(OP_ORA, 8'h01, 8'h80, 1'b0, 1'b0);
        send(OP_DEC, 8'h10, 8'h00, 1'b0, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("inflight_rst_valid", 32'(out_valid), 0);
        chk("inflight_rst_result", 32'(result), 0);
        chk("inflight_rst_flags", {28'd0, carry_out, overflow, zero, negative}, 0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_no_output", 32'(out_valid), 0);
        @(posedge clk); #1;

        // 16-bit decimal carry ripple through all nibbles
        op16 = OP_ADC; a16 = 16'h9999; b16 = 16'h0001; carry_in16 = 1'b0; decimal16 = 1'b1;
        in_valid16 = 1'b1;
        @(negedge clk);
        chk("w16_in_ready", 32'(in_ready16), 1);
        @(posedge clk); #1 in_valid16 = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid16;
        end
        chk("w16_out_valid", 32'(seen), 1);
        chk("w16_result", 32'(result16), 32'h0000);
        chk("w16_carry_zero", {30'd0, carry_out16, zero16}, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter DECIMAL_EN, default 1, enables BCD mode for ADC/SBC; when 0 the decimal input SHALL be ignored.
REQ-003 One clock; reset is asynchronous and active-low. Ports SHALL be, in order:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  request valid
  in_ready  out  1  request accepted when in_valid & in_ready
  op  in  4  alu_op_t opcode
  a  in  WIDTH  operand A
  b  in  WIDTH  operand B
  carry_in  in  1  carry/borrow-not input
  decimal  in  1  BCD mode for ADC/SBC
  out_valid  out  1  result valid
  out_ready  in  1  consumer accepts when out_valid & out_ready
  result  out  WIDTH  result
  carry_out  out  1  C flag
  overflow  out  1  V flag
  zero  out  1  Z flag, result == 0
  negative  out  1  N flag, result[WIDTH-1]

Function
REQ-004 Opcodes SHALL be ADC, SBC, AND, ORA, EOR, ASL, LSR, ROL, ROR, INC, DEC, CMP, PASS; undefined codes behave as PASS.
REQ-005 Binary ADC: {C,result} = a + b + carry_in; V = MSB of (a^result)&(b^result).
REQ-006 Binary SBC SHALL equal ADC with b replaced by ~b; C=1 means no borrow.
REQ-007 CMP SHALL compute a + ~b + 1 (carry_in ignored); result = difference, C = (a >= b unsigned), V = 0.
REQ-008 AND/ORA/EOR/PASS: bitwise result (PASS = a); C = carry_in, V = 0.
REQ-009 ASL/LSR: shift a by one, fill 0, C = bit shifted out; ROL/ROR fill with carry_in, C = bit shifted out; V = 0.
REQ-010 INC/DEC: a +/- 1 modulo 2^WIDTH; C = carry_in, V = 0.
REQ-011 Decimal ADC (DECIMAL_EN=1, decimal=1): per nibble from LSB, add 6 when nibble sum > 9, carrying into next nibble; C = carry out of top nibble.
REQ-012 Decimal SBC: per nibble, subtract 6 when nibble borrowed; C = no borrow from top nibble.
REQ-013 In decimal mode V SHALL be the binary-mode V; Z and N SHALL come from the final adjusted result.
REQ-014 Pipeline SHALL have two stages: S1 registers binary result and carries (incl. per-nibble carries); S2 registers decimal adjust and flags.
REQ-015 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready stays high; throughput one op per cycle.
REQ-016 Stage advances when its downstream is empty or being consumed; in_ready = !S1_full | S1_advances (combinational, no dependency on in_valid).
REQ-017 While out_valid & !out_ready, result and all flags SHALL hold stable; at most 2 ops in flight, none dropped or duplicated.
REQ-018 Simultaneous accept into S1 and consume from S2 in one cycle SHALL be lossless.

Reset
REQ-019 rst_n low SHALL asynchronously clear both stage-valid bits; out_valid = 0, result = 0, all flags = 0.
REQ-020 In-flight ops at reset SHALL be discarded; in_ready SHALL be 1 in the first cycle after deassertion.

Structure
REQ-021 Package alu_pkg SHALL hold alu_op_t (4-bit enum) and opcode constants, shared with the decoder.
REQ-022 Sub-module bcd_adjust (one nibble, add/sub select) SHALL be instantiated WIDTH/4 times in S2.

Verification
REQ-023 ADC a=0x50 b=0x50 c=0 binary -> result 0xA0, C=0, V=1, N=1, Z=0, out_valid 2 cycles after accept.
REQ-024 Decimal ADC a=0x58 b=0x46 c=1 -> result 0x05, C=1; decimal SBC a=0x46 b=0x12 c=1 -> 0x34, C=1.
REQ-025 SBC a=0x00 b=0x01 c=1 -> 0xFF, C=0, N=1; CMP a=0x10 b=0x10 -> 0x00, C=1, Z=1.
REQ-026 ROR a=0x01 c=1 -> 0x80, C=1, N=1; ASL a=0x80 -> 0x00, C=1, Z=1.
REQ-027 Back-to-back stream, out_ready low 3 cycles: in_ready drops once 2 ops held, outputs stable, order preserved.
REQ-028 rst_n low with 2 ops in flight -> out_valid 0 immediately; WIDTH=16 ADC 0x9999+0x0001 decimal -> 0x0000, C=1.
